// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ==========================================================================
// muldiv_unit_pkg : shared core defines (ALU and RV32M op encodings)
// Rev 1.0
// ==========================================================================
package muldiv_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } control_alu_op_e;

  // Bit 2 separates the divide class from the multiply class.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } control_muldiv_op_e;

  function automatic logic is_div_op(input control_muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input control_muldiv_op_e op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_rem_op(input control_muldiv_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ==========================================================================
// muldiv_unit_if : request/response bundle between execute stage and muldiv
// Rev 1.0
// ==========================================================================
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic [XLEN-1:0]    a;
  logic [XLEN-1:0]    b;
  control_muldiv_op_e op;
  logic               req_valid;
  logic               flush;
  logic               ready;
  logic               busy;
  logic               rsp_valid;
  logic [XLEN-1:0]    result;

  modport master (
    output a, b, op, req_valid, flush,
    input  ready, busy, rsp_valid, result
  );

  modport slave (
    input  a, b, op, req_valid, flush,
    output ready, busy, rsp_valid, result
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_divider.sv
`default_nettype none
// ==========================================================================
// muldiv_divider : 32-step radix-2 restoring divider on unsigned magnitudes
// Rev 1.0
// ==========================================================================
module muldiv_divider
  import muldiv_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic            running;
  logic [4:0]      count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   rem_shift;
  logic            fits;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;

  // When the divisor fits, the true difference is below 2^32, so a 32-bit subtract suffices.
  always_comb begin
    rem_shift = {rem, quo[XLEN-1]};
    fits      = rem_shift >= {1'b0, dvs};
    quo_next  = {quo[XLEN-2:0], fits};
    rem_next  = fits ? (rem_shift[XLEN-1:0] - dvs) : rem_shift[XLEN-1:0];
  end

  // Results are presented combinationally alongside done so the caller can register them.
  assign done      = running && (count == 5'd31);
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running <= 1'b0;
      count   <= 5'd0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
    end else if (abort) begin
      running <= 1'b0;
      count   <= 5'd0;
    end else if (start) begin
      running <= 1'b1;
      count   <= 5'd0;
      quo     <= dividend;
      rem     <= '0;
      dvs     <= divisor;
    end else if (running) begin
      quo   <= quo_next;
      rem   <= rem_next;
      count <= count + 5'd1;
      if (count == 5'd31) begin
        running <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ==========================================================================
// muldiv_unit : RV32M multiply/divide unit (2-cycle mul, 33-cycle div)
// Rev 1.0
// ==========================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [XLEN-1:0]    a_i,
  input  logic [XLEN-1:0]    b_i,
  input  control_muldiv_op_e ctrl_muldiv_op_i,
  input  logic               valid_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               valid_o,
  output logic [XLEN-1:0]    result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state;
  state_e             state_next;
  control_muldiv_op_e op_q;
  logic [XLEN-1:0]    a_q;
  logic [XLEN-1:0]    b_q;
  logic [XLEN-1:0]    result_q;
  logic               neg_quo;
  logic               neg_rem;

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [XLEN-1:0]    a_mag;
  logic [XLEN-1:0]    b_mag;
  logic               div_zero;
  logic               div_ovf;
  logic               div_special;
  logic [XLEN-1:0]    special_res;
  logic               div_start;
  logic               div_done;
  logic [XLEN-1:0]    div_quo;
  logic [XLEN-1:0]    div_rem;
  logic [XLEN-1:0]    div_res;
  logic               a_top;
  logic               b_top;
  logic [2*XLEN-1:0]  product;
  logic [XLEN-1:0]    mul_res;

  assign accept = valid_i && (state == IDLE) && !flush_i;

  always_comb begin
    a_neg       = is_signed_div(ctrl_muldiv_op_i) && a_i[XLEN-1];
    b_neg       = is_signed_div(ctrl_muldiv_op_i) && b_i[XLEN-1];
    a_mag       = a_neg ? -a_i : a_i;
    b_mag       = b_neg ? -b_i : b_i;
    div_zero    = (b_i == '0);
    div_ovf     = is_signed_div(ctrl_muldiv_op_i) && (a_i == 32'h8000_0000) && (b_i == '1);
    div_special = div_zero || div_ovf;
    if (div_zero) begin
      special_res = is_rem_op(ctrl_muldiv_op_i) ? a_i : '1;
    end else begin
      special_res = is_rem_op(ctrl_muldiv_op_i) ? '0 : 32'h8000_0000;
    end
  end

  assign div_start = accept && is_div_op(ctrl_muldiv_op_i) && !div_special;

  muldiv_divider u_divider (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_res = is_rem_op(op_q) ? (neg_rem ? -div_rem : div_rem)
                                   : (neg_quo ? -div_quo : div_quo);

  // Sign-extend to 64 bits per operand signedness; the low 64 bits of the product are exact.
  always_comb begin
    a_top   = (op_q != MD_MULHU) && a_q[XLEN-1];
    b_top   = ((op_q == MD_MUL) || (op_q == MD_MULH)) && b_q[XLEN-1];
    product = {{XLEN{a_top}}, a_q} * {{XLEN{b_top}}, b_q};
    mul_res = (op_q == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    busy_o     = 1'b1;
    valid_o    = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (accept) begin
          if (!is_div_op(ctrl_muldiv_op_i)) begin
            state_next = MUL;
          end else if (div_special) begin
            state_next = DONE;
          end else begin
            state_next = DIV;
          end
        end
      end
      MUL: state_next = flush_i ? IDLE : DONE;
      DIV: begin
        if (flush_i) begin
          state_next = IDLE;
        end else if (div_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        valid_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= ctrl_muldiv_op_i;
      a_q     <= a_i;
      b_q     <= b_i;
      neg_quo <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (is_div_op(ctrl_muldiv_op_i) && div_special) begin
        result_q <= special_res;
      end
    end else if (!flush_i) begin
      if (state == MUL) begin
        result_q <= mul_res;
      end else if ((state == DIV) && div_done) begin
        result_q <= div_res;
      end
    end
  end

  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ==========================================================================
// tb_muldiv_unit : directed scoreboard bench for muldiv_unit
// Rev 1.0
// ==========================================================================
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .a_i              (bus.a),
    .b_i              (bus.b),
    .ctrl_muldiv_op_i (bus.op),
    .valid_i          (bus.req_valid),
    .flush_i          (bus.flush),
    .ready_o          (bus.ready),
    .busy_o           (bus.busy),
    .valid_o          (bus.rsp_valid),
    .result_o         (bus.result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every response pops one expectation, checking value and arrival cycle.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Called at posedge+1 of the intended acceptance cycle; returns at posedge+1 of cycle 1.
  task automatic issue(input control_muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit track);
    exp_t e;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.req_valid = 1'b1;
    chk("ready_at_issue", 32'(bus.ready), 32'd1);
    if (track) begin
      e.res = exp;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.op        = control_muldiv_op_e'(3'($urandom_range(0, 7)));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = MD_MUL;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply class
    issue(MD_MUL,    32'd3000,       32'd1500,       32'h0044_AA20, 2, 1'b1); drain();
    issue(MD_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 2, 1'b1); drain();
    issue(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 2, 1'b1); drain();
    issue(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 2, 1'b1); drain();
    issue(MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 2, 1'b1); drain();
    issue(MD_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 2, 1'b1); drain();

    // Requests while busy must be ignored (a second accept would show as an extra valid_o)
    issue(MD_MUL, 32'd7, 32'd6, 32'd42, 2, 1'b1);
    bus.req_valid = 1'b1;
    bus.op        = MD_MULHU;
    bus.a         = 32'd5;
    bus.b         = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain();

    // Signed division with busy profile
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("busy_during_div", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    chk("busy_after_div", 32'(bus.busy), 32'd0);
    drain();
    issue(MD_REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33, 1'b1); drain();
    issue(MD_DIV,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 33, 1'b1); drain();
    issue(MD_REM,  32'd7,         32'hFFFF_FFFE,  32'd1,         33, 1'b1); drain();
    issue(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         33, 1'b1); drain();
    issue(MD_REMU, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 33, 1'b1); drain();

    // Divide by zero and signed overflow short paths
    issue(MD_DIVU, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 1, 1'b1); drain();
    issue(MD_REMU, 32'h0000_1234, 32'd0,          32'h0000_1234, 1, 1'b1); drain();
    issue(MD_DIV,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 1, 1'b1); drain();
    issue(MD_REM,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 1, 1'b1); drain();
    issue(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1, 1'b1); drain();
    issue(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1, 1'b1); drain();

    // Flush in cycle 10 of a divide, then a fresh divide accepted in cycle 11
    issue(MD_DIV, 32'd100, 32'd7, 32'd0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_ready", 32'(bus.ready), 32'd1);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    issue(MD_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1); drain();
    issue(MD_REMU, 32'd100, 32'd7, 32'd2,  33, 1'b1); drain();

    // Asynchronous reset in cycle 5 of a divide
    issue(MD_DIV, 32'd100, 32'd7, 32'd0, 33, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_ready", 32'(bus.ready), 32'd1);
    chk("midop_reset_busy", 32'(bus.busy), 32'd0);
    chk("midop_reset_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midop_reset_result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(MD_MUL, 32'd3000, 32'd1500, 32'h0044_AA20, 2, 1'b1); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_ni SHALL be asynchronous and active-low.
REQ-002 The block SHALL have exactly the following ports, in the order listed:
- clk_i  input  1  clock.
- rst_ni  input  1  async active-low reset.
- a_i  input  32  operand A (rs1), same source as the ALU a_i.
- b_i  input  32  operand B (rs2).
- ctrl_muldiv_op_i  input  control_muldiv_op_e  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- valid_i  input  1  request strobe from execute stage.
- flush_i  input  1  pipeline flush, synchronous abort.
- ready_o  output  1  block can accept a request.
- busy_o  output  1  operation in flight; drives the pipeline stall.
- valid_o  output  1  result_o valid, single-cycle pulse.
- result_o  output  32  RV32M result.

Function
REQ-003 The state machine SHALL have exactly the states IDLE, MUL, DIV and DONE.
REQ-004 ready_o SHALL be 1 only in IDLE; busy_o SHALL be 1 in every state except IDLE.
REQ-005 A request SHALL be accepted at a rising edge where valid_i=1, ready_o=1 and flush_i=0; the operands and the op SHALL be latched at that edge. Cycle 0 is the acceptance cycle.
REQ-006 MUL-class ops SHALL take the transitions IDLE->MUL->DONE: the 64-bit product is registered in cycle 1, and valid_o=1 in cycle 2.
REQ-007 Product signedness SHALL be: MUL/MULH signed x signed; MULHSU signed A x unsigned B; MULHU unsigned x unsigned.
REQ-008 MUL SHALL return product[31:0]; the MULH variants SHALL return product[63:32].
REQ-009 Normal DIV-class ops SHALL take IDLE->DIV->DONE and SHALL use radix-2 restoring division on operand magnitudes.
REQ-010 The division SHALL iterate 32 times in cycles 1..32, driven by a 5-bit counter that wraps from 31 to 0 on exit; sign correction happens in cycle 33, with valid_o=1 in cycle 33.
REQ-011 Signed quotient sign SHALL be sign(A) XOR sign(B); signed remainder sign SHALL equal sign(A).
REQ-012 Divide-by-zero (b=0) SHALL go IDLE->DONE with valid_o=1 in cycle 1.
- Quotient: 0xFFFFFFFF.
- Remainder: A.
REQ-013 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF) SHALL go IDLE->DONE with valid_o=1 in cycle 1.
- Quotient: 0x80000000.
- Remainder: 0.
REQ-014 DONE SHALL last exactly one cycle and then return to IDLE; a new request SHALL be accepted no earlier than the cycle after DONE.
REQ-015 result_o SHALL hold its last value until the next DONE.
REQ-016 valid_i SHALL be ignored while ready_o=0.
REQ-017 flush_i=1 in MUL, DIV or DONE SHALL force IDLE at the next edge and suppress a valid_o that has not yet been issued.
REQ-018 flush_i=1 together with valid_i=1 in IDLE SHALL cause no acceptance.
REQ-019 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-020 Reset SHALL act asynchronously, including when asserted mid-operation.
REQ-021 Reset SHALL set the state to IDLE and zero all internal registers.
REQ-022 Output values while in reset: ready_o=1, busy_o=0, valid_o=0, result_o=0.
REQ-023 Release from reset SHALL take effect at the first rising edge after rst_ni goes high.

Structure
REQ-024 control_muldiv_op_e (3-bit) SHALL live in the shared core defines package alongside control_alu_op_e.
REQ-025 The state enum SHALL be local to the module.
REQ-026 The iterative divider datapath SHALL be one sub-module, muldiv_divider, with start/done handshake; the multiplier SHALL stay inline.

Verification
REQ-027 Bench directed scenarios:
- MUL 3000 x 1500 -> result_o=4500000 (0x0044AA20), valid_o in cycle 2 only.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD and REM -7%2 -> 0xFFFFFFFF, valid_o in cycle 33; busy_o=1 in cycles 1..33.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REMU -> 0x1234, in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, in cycle 1.
- DIV 100/7 with flush_i in cycle 10 -> no valid_o, ready_o=1 in cycle 11; a new DIVU 100/7 accepted then -> 14, REMU -> 2.
- rst_ni low in cycle 5 of a DIV -> immediate IDLE, outputs at reset values, no valid_o after release.
